// File: rtl/instr_fetch.sv
// Instruction fetch unit: issues one address on the instruction bus per start,
// returns the fetched word or an address-error/bus-timeout exception via done.
module instr_fetch #(
    parameter int unsigned WAIT_LIMIT  = 0,
    parameter logic [31:0] RESET_INSTR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        start,
    input  logic [31:0] pc,
    input  logic        flush,
    output logic        ireq_valid,
    output logic [31:0] ireq_addr,
    input  logic        ireq_ready,
    input  logic        iresp_valid,
    input  logic [31:0] iresp_data,
    output logic        done,
    output logic [31:0] instr,
    output logic        ex_adel,
    output logic        ex_bus,
    output logic        busy
);

    localparam int unsigned     CNT_W      = (WAIT_LIMIT < 2) ? 1 : $clog2(WAIT_LIMIT + 1);
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(WAIT_LIMIT);
    localparam bit              TIMEOUT_EN = (WAIT_LIMIT != 0);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_DROP
    } state_t;

    state_t           state, state_n;
    logic [CNT_W-1:0] wait_cnt, wait_cnt_n;
    logic             ireq_valid_n;
    logic [31:0]      ireq_addr_n;
    logic             done_n;
    logic [31:0]      instr_n;
    logic             ex_adel_n;
    logic             ex_bus_n;
    logic             busy_n;

    // State and all outputs are registered together.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state      <= S_IDLE;
            wait_cnt   <= '0;
            ireq_valid <= 1'b0;
            ireq_addr  <= 32'h0;
            done       <= 1'b0;
            instr      <= RESET_INSTR;
            ex_adel    <= 1'b0;
            ex_bus     <= 1'b0;
            busy       <= 1'b0;
        end else begin
            state      <= state_n;
            wait_cnt   <= wait_cnt_n;
            ireq_valid <= ireq_valid_n;
            ireq_addr  <= ireq_addr_n;
            done       <= done_n;
            instr      <= instr_n;
            ex_adel    <= ex_adel_n;
            ex_bus     <= ex_bus_n;
            busy       <= busy_n;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_n     = state;
        wait_cnt_n  = wait_cnt;
        ireq_addr_n = ireq_addr;
        instr_n     = instr;
        done_n      = 1'b0;
        ex_adel_n   = 1'b0;
        ex_bus_n    = 1'b0;

        unique case (state)
            S_IDLE: begin
                if (start) begin
                    if (pc[1:0] != 2'b00) begin
                        done_n    = 1'b1;
                        ex_adel_n = 1'b1;
                    end else begin
                        ireq_addr_n = pc;
                        state_n     = S_REQ;
                    end
                end
            end

            S_REQ: begin
                if (ireq_ready) begin
                    // Address accepted: a flush must still absorb its response,
                    // unless that response arrives in this very cycle.
                    if (flush) begin
                        state_n = iresp_valid ? S_IDLE : S_DROP;
                    end else if (iresp_valid) begin
                        instr_n = iresp_data;
                        done_n  = 1'b1;
                        state_n = S_IDLE;
                    end else begin
                        wait_cnt_n = '0;
                        state_n    = S_WAIT;
                    end
                end else if (flush) begin
                    state_n = S_IDLE;
                end
            end

            S_WAIT: begin
                if (flush) begin
                    state_n = iresp_valid ? S_IDLE : S_DROP;
                end else if (iresp_valid) begin
                    instr_n = iresp_data;
                    done_n  = 1'b1;
                    state_n = S_IDLE;
                end else if (TIMEOUT_EN) begin
                    wait_cnt_n = wait_cnt + CNT_W'(1);
                    if (wait_cnt_n == CNT_LIMIT) begin
                        done_n   = 1'b1;
                        ex_bus_n = 1'b1;
                        state_n  = S_DROP;
                    end
                end
            end

            S_DROP: begin
                if (iresp_valid) begin
                    state_n = S_IDLE;
                end
            end

            default: state_n = S_IDLE;
        endcase

        ireq_valid_n = (state_n == S_REQ);
        busy_n       = (state_n != S_IDLE);
    end

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: bus driven directly, done results
// checked against a queue of expected completions.
module tb_instr_fetch;

    localparam logic [31:0] RST_INSTR = 32'hA5A5_0000;

    typedef struct packed {
        logic [31:0] instr;
        logic        adel;
        logic        bus;
    } exp_t;

    logic        clk = 1'b0;
    logic        resetn;
    logic        start;
    logic [31:0] pc;
    logic        flush;
    logic        ireq_valid;
    logic [31:0] ireq_addr;
    logic        ireq_ready;
    logic        iresp_valid;
    logic [31:0] iresp_data;
    logic        done;
    logic [31:0] instr;
    logic        ex_adel;
    logic        ex_bus;
    logic        busy;

    int          n_vec = 0;
    int          n_err = 0;
    exp_t        sb[$];
    logic [31:0] last_instr;

    instr_fetch #(
        .WAIT_LIMIT (4),
        .RESET_INSTR(RST_INSTR)
    ) dut (
        .clk        (clk),
        .resetn     (resetn),
        .start      (start),
        .pc         (pc),
        .flush      (flush),
        .ireq_valid (ireq_valid),
        .ireq_addr  (ireq_addr),
        .ireq_ready (ireq_ready),
        .iresp_valid(iresp_valid),
        .iresp_data (iresp_data),
        .done       (done),
        .instr      (instr),
        .ex_adel    (ex_adel),
        .ex_bus     (ex_bus),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic expect_done(input logic [31:0] w, input logic adel, input logic bus);
        sb.push_back('{instr: w, adel: adel, bus: bus});
        last_instr = w;
    endtask

    task automatic start_fetch(input logic [31:0] a);
        start = 1'b1;
        pc    = a;
        cyc(1);
        start = 1'b0;
        pc    = 32'h0;
    endtask

    task automatic handshake(input logic with_resp, input logic [31:0] d);
        ireq_ready  = 1'b1;
        iresp_valid = with_resp;
        iresp_data  = d;
        cyc(1);
        ireq_ready  = 1'b0;
        iresp_valid = 1'b0;
    endtask

    task automatic respond(input logic [31:0] d);
        iresp_valid = 1'b1;
        iresp_data  = d;
        cyc(1);
        iresp_valid = 1'b0;
    endtask

    // Completion monitor: every done must match the oldest expectation.
    always @(negedge clk) begin
        exp_t e;
        if (resetn) begin
            if (!done) begin
                check("ex_without_done", {30'h0, ex_adel, ex_bus}, 32'h0);
            end else if (sb.size() == 0) begin
                check("spurious_done", 32'(done), 32'h0);
            end else begin
                e = sb.pop_front();
                check("done_instr", instr, e.instr);
                check("done_ex_adel", 32'(ex_adel), 32'(e.adel));
                check("done_ex_bus", 32'(ex_bus), 32'(e.bus));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, %0d vectors, %0d miscompares", n_vec, n_err);
        $fatal(1);
    end

    initial begin
        resetn      = 1'b0;
        start       = 1'b0;
        pc          = 32'h0;
        flush       = 1'b0;
        ireq_ready  = 1'b0;
        iresp_valid = 1'b0;
        iresp_data  = 32'h0;
        last_instr  = RST_INSTR;
        cyc(2);
        check("rst_ireq_valid", 32'(ireq_valid), 32'h0);
        check("rst_ireq_addr", ireq_addr, 32'h0);
        check("rst_done", 32'(done), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_instr", instr, RST_INSTR);
        resetn = 1'b1;
        cyc(1);

        // Normal fetch, response one cycle after the handshake.
        start_fetch(32'hBFC0_0000);
        check("t1_req_valid", 32'(ireq_valid), 32'h1);
        check("t1_req_addr", ireq_addr, 32'hBFC0_0000);
        handshake(1'b0, 32'h0);
        check("t1_wait_valid", 32'(ireq_valid), 32'h0);
        check("t1_wait_busy", 32'(busy), 32'h1);
        expect_done(32'h2408_0001, 1'b0, 1'b0);
        respond(32'h2408_0001);
        check("t1_done", 32'(done), 32'h1);
        check("t1_addr", ireq_addr, 32'hBFC0_0000);
        cyc(1);
        check("t1_done_pulse", 32'(done), 32'h0);

        // Misaligned pc: immediate AdEL, no bus request.
        expect_done(last_instr, 1'b1, 1'b0);
        start_fetch(32'hBFC0_0002);
        check("t2_done", 32'(done), 32'h1);
        check("t2_adel", 32'(ex_adel), 32'h1);
        check("t2_no_req", 32'(ireq_valid), 32'h0);
        check("t2_busy", 32'(busy), 32'h0);
        cyc(1);
        check("t2_done_pulse", 32'(done), 32'h0);
        check("t2_no_req2", 32'(ireq_valid), 32'h0);

        // Ready held low: request stable, stray start ignored; then same-cycle response.
        start_fetch(32'hBFC0_0010);
        for (int i = 0; i < 5; i++) begin
            check("t3_hold_valid", 32'(ireq_valid), 32'h1);
            check("t3_hold_addr", ireq_addr, 32'hBFC0_0010);
            if (i == 2) begin
                start = 1'b1;
                pc    = 32'hBFC0_0100;
            end
            cyc(1);
            start = 1'b0;
        end
        expect_done(32'h8C82_0004, 1'b0, 1'b0);
        handshake(1'b1, 32'h8C82_0004);
        check("t3_done", 32'(done), 32'h1);
        check("t3_idle", 32'(busy), 32'h0);

        // Flush in REQ before handshake.
        start_fetch(32'hBFC0_0040);
        flush = 1'b1;
        cyc(1);
        flush = 1'b0;
        check("t4_valid", 32'(ireq_valid), 32'h0);
        check("t4_busy", 32'(busy), 32'h0);

        // Flush in WAIT, stale response dropped, then a fresh fetch.
        start_fetch(32'hBFC0_0020);
        handshake(1'b0, 32'h0);
        cyc(1);
        flush = 1'b1;
        cyc(1);
        flush = 1'b0;
        check("t5_drop_busy", 32'(busy), 32'h1);
        check("t5_drop_valid", 32'(ireq_valid), 32'h0);
        respond(32'hDEAD_BEEF);
        check("t5_stale_done", 32'(done), 32'h0);
        check("t5_idle", 32'(busy), 32'h0);
        expect_done(32'h0000_0000, 1'b0, 1'b0);
        start_fetch(32'hBFC0_0004);
        check("t5_req_addr", ireq_addr, 32'hBFC0_0004);
        handshake(1'b0, 32'h0);
        respond(32'h0000_0000);
        check("t5_done", 32'(done), 32'h1);
        check("t5_instr", instr, 32'h0000_0000);

        // Flush and response in the same WAIT cycle: response consumed, no done.
        start_fetch(32'hBFC0_0050);
        handshake(1'b0, 32'h0);
        flush       = 1'b1;
        iresp_valid = 1'b1;
        iresp_data  = 32'hCAFE_F00D;
        cyc(1);
        flush       = 1'b0;
        iresp_valid = 1'b0;
        check("t6_done", 32'(done), 32'h0);
        check("t6_idle", 32'(busy), 32'h0);
        respond(32'h1111_1111);
        check("t6_orphan_done", 32'(done), 32'h0);
        check("t6_orphan_busy", 32'(busy), 32'h0);

        // Timeout after 4 WAIT cycles, then DROP until the late response.
        expect_done(last_instr, 1'b0, 1'b1);
        start_fetch(32'hBFC0_0030);
        handshake(1'b0, 32'h0);
        cyc(3);
        check("t7_early", 32'(done), 32'h0);
        cyc(1);
        check("t7_done", 32'(done), 32'h1);
        check("t7_ex_bus", 32'(ex_bus), 32'h1);
        check("t7_busy", 32'(busy), 32'h1);
        start = 1'b1;
        pc    = 32'hBFC0_0060;
        cyc(1);
        start = 1'b0;
        cyc(2);
        check("t7_drop_busy", 32'(busy), 32'h1);
        check("t7_drop_valid", 32'(ireq_valid), 32'h0);
        respond(32'h7777_7777);
        check("t7_late_done", 32'(done), 32'h0);
        check("t7_late_idle", 32'(busy), 32'h0);
        check("t7_instr", instr, last_instr);

        // Asynchronous reset in WAIT.
        start_fetch(32'hBFC0_0070);
        handshake(1'b0, 32'h0);
        cyc(1);
        resetn = 1'b0;
        #1;
        check("t8_valid", 32'(ireq_valid), 32'h0);
        check("t8_addr", ireq_addr, 32'h0);
        check("t8_done", 32'(done), 32'h0);
        check("t8_busy", 32'(busy), 32'h0);
        check("t8_instr", instr, RST_INSTR);
        last_instr = RST_INSTR;
        @(negedge clk);
        resetn = 1'b1;
        cyc(1);
        respond(32'h5555_5555);
        check("t8_resp_done", 32'(done), 32'h0);
        check("t8_resp_busy", 32'(busy), 32'h0);
        check("t8_resp_instr", instr, RST_INSTR);

        cyc(2);
        check("sb_empty", 32'(sb.size()), 32'h0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
